// File: rtl/axis_pkt_pkg.sv
// Shared types and widths for the AXI-Stream packet generator.
package axis_pkt_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Loaded into the gap counter on the last beat; it counts down to zero inside GAP.
  function automatic logic [7:0] gap_load(input int gap_cycles);
    return (gap_cycles == 0) ? 8'd0 : 8'(gap_cycles - 1);
  endfunction

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: one command yields cmd_len+1 incrementing beats from cmd_seed.
// Optional macro AXIS_PKT_GEN_TERR_EN drives m_axis_terr from cmd_err on the last beat.
module axis_pkt_gen
  import axis_pkt_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  input  logic              cmd_id,
  input  logic              cmd_dest,
  input  logic              cmd_err,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tid,
  output logic              m_axis_tdest,
  output logic              m_axis_tlast,
  output logic              m_axis_tkeep,
  output logic              m_axis_terr,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam logic [7:0] GAP_LOAD = gap_load(GAP_CYCLES);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [7:0]         gap_cnt;
  logic               cmd_fire, beat_fire, last_fire, next_last;

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = m_axis_tvalid && m_axis_tready;
  assign last_fire = beat_fire && (beat_cnt == len_q);
  assign next_last = ((beat_cnt + 8'd1) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire) state_nxt = SEND;
      SEND: if (last_fire) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                    gap_cnt <= 8'd0;
    else if (last_fire)                         gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != 8'd0)   gap_cnt <= gap_cnt - 8'd1;
  end

  // The tdata register doubles as the latched seed; each accepted beat bumps it by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= 1'b0;
      m_axis_tid    <= 1'b0;
      m_axis_tdest  <= 1'b0;
      pkt_count     <= '0;
    end else if (cmd_fire) begin
      len_q         <= cmd_len;
      beat_cnt      <= '0;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= cmd_seed;
      m_axis_tlast  <= (cmd_len == '0);
      m_axis_tkeep  <= 1'b1;
      m_axis_tid    <= cmd_id;
      m_axis_tdest  <= cmd_dest;
    end else if (beat_fire) begin
      if (beat_cnt == len_q) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tkeep  <= 1'b0;
        pkt_count     <= pkt_count + 16'd1;
      end else begin
        beat_cnt      <= beat_cnt + 8'd1;
        m_axis_tdata  <= m_axis_tdata + 8'd1;
        m_axis_tlast  <= next_last;
      end
    end
  end

`ifdef AXIS_PKT_GEN_TERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      m_axis_terr <= 1'b0;
    end else if (cmd_fire) begin
      err_q       <= cmd_err;
      m_axis_terr <= cmd_err && (cmd_len == '0);
    end else if (beat_fire) begin
      m_axis_terr <= (beat_cnt == len_q) ? 1'b0 : (err_q && next_last);
    end
  end
`else
  logic unused_cmd_err;
  assign unused_cmd_err = cmd_err;
  assign m_axis_terr    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: instances with GAP_CYCLES=0 and 3, a beat-level reference model, directed table and random traffic.
module tb_axis_pkt_gen;

  localparam int G1 = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       cv;
  logic [7:0]       c_len, c_seed;
  logic             c_id, c_dest, c_err;
  logic             tready;
  logic [1:0]       crdy, tvalid, tid, tdest, tlast, tkeep, terr, busy;
  logic [1:0][7:0]  tdata;
  logic [1:0][15:0] pcnt;

  always #5 clk = ~clk;

  axis_pkt_gen #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(crdy[0]), .cmd_len(c_len), .cmd_seed(c_seed),
    .cmd_id(c_id), .cmd_dest(c_dest), .cmd_err(c_err), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready),
    .m_axis_tid(tid[0]), .m_axis_tdest(tdest[0]), .m_axis_tlast(tlast[0]), .m_axis_tkeep(tkeep[0]),
    .m_axis_terr(terr[0]), .m_axis_tdata(tdata[0]), .busy(busy[0]), .pkt_count(pcnt[0]));

  axis_pkt_gen #(.GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(crdy[1]), .cmd_len(c_len), .cmd_seed(c_seed),
    .cmd_id(c_id), .cmd_dest(c_dest), .cmd_err(c_err), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready),
    .m_axis_tid(tid[1]), .m_axis_tdest(tdest[1]), .m_axis_tlast(tlast[1]), .m_axis_tkeep(tkeep[1]),
    .m_axis_terr(terr[1]), .m_axis_tdata(tdata[1]), .busy(busy[1]), .pkt_count(pcnt[1]));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: a packet is (seed, len, id, dest, err) plus a beat index k.
  bit         in_pkt[2], after_rst[2], mon_en;
  int         gap_left[2], cnt[2], k[2], hs[2], acc[2], last_cyc[2], spacing[2], cyc;
  logic [7:0] ps[2], pl[2], last_d[2];
  logic       pid[2], pdest[2], perr[2];

  initial begin
    bit eb, el;
    logic [7:0] ed;
    mon_en = 0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      in_pkt[i] = 0; after_rst[i] = 0; gap_left[i] = 0; cnt[i] = 0; k[i] = 0;
      hs[i] = 0; acc[i] = 0; last_cyc[i] = 0; spacing[i] = 0; last_d[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (mon_en) begin
          eb = in_pkt[i] || (gap_left[i] > 0);
          chk("tvalid", i, tvalid[i], in_pkt[i]);
          chk("busy", i, busy[i], eb);
          chk("cmd_ready", i, crdy[i], !rst && !eb);
          chk("pkt_count", i, pcnt[i], 32'(cnt[i][15:0]));
          if (in_pkt[i]) begin
            ed = ps[i] + 8'(k[i]);
`ifdef AXIS_PKT_GEN_TERR_EN
            el = perr[i] && (k[i] == int'(pl[i]));
`else
            el = 1'b0;
`endif
            chk("tdata", i, tdata[i], ed);
            chk("tlast", i, tlast[i], k[i] == int'(pl[i]));
            chk("tkeep", i, tkeep[i], 1);
            chk("tid", i, tid[i], pid[i]);
            chk("tdest", i, tdest[i], pdest[i]);
            chk("terr", i, terr[i], el);
          end else if (after_rst[i]) begin
            chk("rst_tdata", i, tdata[i], 0);
            chk("rst_side", i, {tlast[i], tkeep[i], terr[i], tid[i], tdest[i]}, 0);
          end
        end
        if (rst) begin
          in_pkt[i] = 0; gap_left[i] = 0; cnt[i] = 0; after_rst[i] = 1;
        end else begin
          after_rst[i] = 0;
          if (in_pkt[i]) begin
            if (tready) begin
              hs[i]++;
              last_d[i] = ps[i] + 8'(k[i]);
              if (k[i] == int'(pl[i])) begin
                in_pkt[i] = 0; cnt[i]++; last_cyc[i] = cyc;
                gap_left[i] = (i == 0) ? 0 : G1;
              end else k[i]++;
            end
          end else if (gap_left[i] > 0) begin
            gap_left[i]--;
          end else if (cv[i]) begin
            in_pkt[i] = 1; k[i] = 0; ps[i] = c_seed; pl[i] = c_len;
            pid[i] = c_id; pdest[i] = c_dest; perr[i] = c_err;
            acc[i]++; spacing[i] = cyc - last_cyc[i];
          end
        end
      end
      if (rst) mon_en = 1;
    end
  end

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  seed;
    logic        id, dest, err;
    logic [15:0] pat;       // tready per cycle after the handshake, LSB first
    int          plen;
    logic [7:0]  exp_last;
    int          exp_n;
  } vec_t;

  vec_t tbl[6];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (busy !== 2'b00 && t < 2000) begin
      step;
      t++;
    end
    if (busy !== 2'b00) begin
      n_vec++; n_mis++;
      $display("FAIL idle_timeout: busy=%b expected 00", busy);
    end
  endtask

  task automatic issue(input logic [7:0] len, input logic [7:0] seed, input logic id, input logic dest, input logic err);
    c_len = len; c_seed = seed; c_id = id; c_dest = dest; c_err = err;
    cv = 2'b11;
    step;
    cv = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0[2], c0[2], a0[2], t;
    rst = 1'b1; cv = 2'b00; tready = 1'b0;
    c_len = '0; c_seed = '0; c_id = 1'b0; c_dest = 1'b0; c_err = 1'b0;

    tbl[0] = '{8'd0,   8'h5A, 1'b1, 1'b0, 1'b0, 16'h0000,   0, 8'h5A,   1};
    tbl[1] = '{8'd3,   8'hFE, 1'b0, 1'b1, 1'b0, 16'h0000,   0, 8'h01,   4};
    tbl[2] = '{8'd2,   8'h10, 1'b1, 1'b1, 1'b0, 16'b110100, 6, 8'h12,   3};
    tbl[3] = '{8'd1,   8'h33, 1'b0, 1'b0, 1'b1, 16'h0000,   0, 8'h34,   2};
    tbl[4] = '{8'd255, 8'h80, 1'b1, 1'b0, 1'b1, 16'h5555,  16, 8'h7F, 256};
    tbl[5] = '{8'd7,   8'hF9, 1'b0, 1'b1, 1'b0, 16'h0F0F,  16, 8'h00,   8};

    repeat (3) step;
    rst = 1'b0;
    step;

    for (int v = 0; v < 6; v++) begin
      wait_idle;
      for (int i = 0; i < 2; i++) begin h0[i] = hs[i]; c0[i] = cnt[i]; end
      tready = 1'b0;
      issue(tbl[v].len, tbl[v].seed, tbl[v].id, tbl[v].dest, tbl[v].err);
      for (int j = 0; j < 2000 && busy != 2'b00; j++) begin
        tready = (j < tbl[v].plen) ? tbl[v].pat[j] : 1'b1;
        step;
      end
      wait_idle;
      for (int i = 0; i < 2; i++) begin
        chk("tbl_nbeats", i, hs[i] - h0[i], tbl[v].exp_n);
        chk("tbl_last_data", i, last_d[i], tbl[v].exp_last);
        chk("tbl_pkt_count", i, pcnt[i], c0[i] + 1);
      end
    end

    // Two queued commands with cmd_valid held: spacing is GAP_CYCLES+1.
    wait_idle;
    for (int i = 0; i < 2; i++) a0[i] = acc[i];
    c_len = 8'd0; c_seed = 8'hA0; tready = 1'b1; cv = 2'b11;
    t = 0;
    while (cv != 2'b00 && t < 50) begin
      step;
      t++;
      for (int i = 0; i < 2; i++) if (acc[i] - a0[i] >= 2) cv[i] = 1'b0;
    end
    if (cv != 2'b00) begin
      n_vec++; n_mis++;
      $display("FAIL gap_timeout: cv=%b expected 00", cv);
    end
    cv = 2'b00;
    chk("gap_spacing", 0, spacing[0], 1);
    chk("gap_spacing", 1, spacing[1], G1 + 1);
    wait_idle;

    // Long stall: beat holds with tready low.
    tready = 1'b0;
    issue(8'd1, 8'h40, 1'b1, 1'b1, 1'b0);
    repeat (40) step;
    for (int i = 0; i < 2; i++) begin
      chk("stall_tvalid", i, tvalid[i], 1);
      chk("stall_tdata", i, tdata[i], 8'h40);
    end
    tready = 1'b1;
    wait_idle;

    // Reset after beat 4 of a 10-beat packet.
    for (int i = 0; i < 2; i++) h0[i] = hs[i];
    tready = 1'b1;
    issue(8'd9, 8'h20, 1'b0, 1'b0, 1'b1);
    t = 0;
    while (hs[0] - h0[0] < 5 && t < 50) begin step; t++; end
    chk("rst_beats_before", 0, hs[0] - h0[0], 5);
    rst = 1'b1;
    step;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mid_tvalid", i, tvalid[i], 0);
      chk("rst_mid_pkt_count", i, pcnt[i], 0);
    end
    rst = 1'b0;
    step;
    for (int i = 0; i < 2; i++) chk("rst_release_ready", i, crdy[i], 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cv     = 2'($urandom);
      c_len  = (($urandom % 8) == 0) ? 8'($urandom % 64) : 8'($urandom % 6);
      c_seed = 8'($urandom);
      c_id   = 1'($urandom);
      c_dest = 1'($urandom);
      c_err  = 1'($urandom);
      tready = (($urandom % 4) != 0);
      rst    = (($urandom % 500) == 0);
      step;
    end
    rst = 1'b0; cv = 2'b00; tready = 1'b1;
    wait_idle;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
